// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road intersection sequencer with pedestrian walk phase
module traffic_intersection_ctrl #(
    parameter int TW       = 6,
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          ped_req,
    output logic [1:0]    ns_led,
    output logic [1:0]    ew_led,
    output logic          walk,
    output logic          ped_wait,
    output logic [TW-1:0] timer_value
);

    localparam logic [2:0] S_ALLRED_A  = 3'd0;
    localparam logic [2:0] S_NS_GREEN  = 3'd1;
    localparam logic [2:0] S_NS_YELLOW = 3'd2;
    localparam logic [2:0] S_ALLRED_B  = 3'd3;
    localparam logic [2:0] S_EW_GREEN  = 3'd4;
    localparam logic [2:0] S_EW_YELLOW = 3'd5;
    localparam logic [2:0] S_PED_WALK  = 3'd6;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [TW-1:0] D_GREEN  = TW'(GREEN_T);
    localparam logic [TW-1:0] D_YELLOW = TW'(YELLOW_T);
    localparam logic [TW-1:0] D_ALLRED = TW'(ALLRED_T);
    localparam logic [TW-1:0] D_WALK   = TW'(WALK_T);

    logic [2:0]    state;
    logic [2:0]    nxt_state;
    logic [TW-1:0] nxt_dur;
    logic          next_dir;
    logic          expire;

    // A phase ends only on the tick that would take the countdown past 1.
    assign expire = tick && (timer_value == TW'(1));

    // Next phase selection; the latched ped_wait (not the live button) decides walk insertion.
    always_comb begin
        nxt_state = state;
        if (expire) begin
            case (state)
                S_ALLRED_A:  nxt_state = ped_wait ? S_PED_WALK : S_NS_GREEN;
                S_NS_GREEN:  nxt_state = S_NS_YELLOW;
                S_NS_YELLOW: nxt_state = S_ALLRED_B;
                S_ALLRED_B:  nxt_state = ped_wait ? S_PED_WALK : S_EW_GREEN;
                S_EW_GREEN:  nxt_state = S_EW_YELLOW;
                S_EW_YELLOW: nxt_state = S_ALLRED_A;
                S_PED_WALK:  nxt_state = (next_dir == DIR_NS) ? S_NS_GREEN : S_EW_GREEN;
                default:     nxt_state = S_ALLRED_A;
            endcase
        end
    end

    // Duration loaded into the countdown when a phase is entered.
    always_comb begin
        nxt_dur = D_ALLRED;
        case (nxt_state)
            S_NS_GREEN, S_EW_GREEN:   nxt_dur = D_GREEN;
            S_NS_YELLOW, S_EW_YELLOW: nxt_dur = D_YELLOW;
            S_PED_WALK:               nxt_dur = D_WALK;
            default:                  nxt_dur = D_ALLRED;
        endcase
    end

    // State, countdown, direction memory, request latch and registered lights.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_ALLRED_A;
            timer_value <= D_ALLRED;
            next_dir    <= DIR_NS;
            ped_wait    <= 1'b0;
            ns_led      <= 2'b00;
            ew_led      <= 2'b00;
            walk        <= 1'b0;
        end else begin
            state <= nxt_state;

            if (expire) begin
                timer_value <= nxt_dur;
            end else if (tick) begin
                timer_value <= timer_value - TW'(1);
            end

            if (expire && state == S_NS_YELLOW) begin
                next_dir <= DIR_EW;
            end else if (expire && state == S_EW_YELLOW) begin
                next_dir <= DIR_NS;
            end

            if (expire && nxt_state == S_PED_WALK) begin
                ped_wait <= 1'b0;
            end else if (ped_req && state != S_PED_WALK) begin
                ped_wait <= 1'b1;
            end

            ns_led <= (nxt_state == S_NS_GREEN)  ? 2'b01 :
                      (nxt_state == S_NS_YELLOW) ? 2'b10 : 2'b00;
            ew_led <= (nxt_state == S_EW_GREEN)  ? 2'b01 :
                      (nxt_state == S_EW_YELLOW) ? 2'b10 : 2'b00;
            walk   <= (nxt_state == S_PED_WALK);
        end
    end

endmodule
